// File: rtl/vme_pkg.sv
// Shared VME definitions: bus levels, A24 address modifiers, responder states and the byte-lane
// decode used by the slave responder.
package vme_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;
    localparam logic DIR_IN   = 1'b0;
    localparam logic DIR_OUT  = 1'b1;

    localparam logic [5:0] AM_A24_USER_DATA = 6'h39;
    localparam logic [5:0] AM_A24_USER_PROG = 6'h3A;
    localparam logic [5:0] AM_A24_SUP_DATA  = 6'h3D;
    localparam logic [5:0] AM_A24_SUP_PROG  = 6'h3E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACCESS,
        ST_ACK,
        ST_ERROR,
        ST_IGNORE,
        ST_WAIT_RELEASE
    } resp_state_e;

    // Bus-level (active-low) inputs; result bit [3] is byte 0, the big-endian MSB lane.
    function automatic logic [3:0] be_from_vme(input logic lword, input logic a1, input logic [1:0] ds);
        logic [3:0] be;
        if (lword == ACTIVE) begin
            be = 4'b1111;
        end else if (ds == {ACTIVE, ACTIVE}) begin
            be = a1 ? 4'b0011 : 4'b1100;
        end else if (ds[1] == ACTIVE) begin
            be = a1 ? 4'b0010 : 4'b1000;
        end else begin
            be = a1 ? 4'b0001 : 4'b0100;
        end
        return be;
    endfunction

endpackage

// File: rtl/vme_sync2.sv
// Two-flop synchroniser for asynchronous VME strobes.
module vme_sync2 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/vme_slave_responder.sv
// VME A24 slave responder: decodes this board's window, issues one local request per bus cycle
// and answers with DTACK, BERR or nothing at all.
//
// state        | meaning
// IDLE         | bus quiet, waiting for AS plus at least one DS
// DECODE       | classify the captured cycle
// ACCESS       | local_req held until ack, err or timeout
// ACK          | DTACK asserted
// ERROR        | BERR asserted
// IGNORE       | not ours, stay off the bus
// WAIT_RELEASE | hold the response until DS, then AS, are released
module vme_slave_responder
    import vme_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR       = 24'hE00000,
    parameter int          WINDOW_BITS     = 20,
    parameter bit          SUPERVISOR_ONLY = 1'b0,
    parameter int          TIMEOUT_CYCLES  = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   vme_as,
    input  logic [1:0]             vme_ds,
    input  logic                   vme_lword,
    input  logic                   vme_write,
    input  logic [5:0]             vme_address_mod,
    input  logic [23:1]            vme_address,
    input  logic                   vme_iack,
    output logic                   vme_dtack,
    output logic                   vme_berr,
    output logic                   data_oe,
    output logic                   data_dir,
    output logic                   local_req,
    output logic                   local_write,
    output logic [WINDOW_BITS-3:0] local_addr,
    output logic [3:0]             local_be,
    input  logic                   local_ack,
    input  logic                   local_err
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic       as_s;
    logic [1:0] ds_s;

    // Synchronisers come out of reset at the active level: a cycle in progress across reset
    // must be seen released before the responder will accept anything.
    vme_sync2 #(.WIDTH(1), .RESET_VAL(ACTIVE)) u_sync_as (
        .clock (clock),
        .reset (reset),
        .d     (vme_as),
        .q     (as_s)
    );

    vme_sync2 #(.WIDTH(2), .RESET_VAL({ACTIVE, ACTIVE})) u_sync_ds (
        .clock (clock),
        .reset (reset),
        .d     (vme_ds),
        .q     (ds_s)
    );

    resp_state_e            state_q, state_d;
    logic [22:0]            addr_q, addr_d;
    logic [5:0]             am_q, am_d;
    logic                   write_q, write_d;
    logic                   lword_q, lword_d;
    logic                   iack_q, iack_d;
    logic [1:0]             ds_q, ds_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   dtack_q, dtack_d;
    logic                   berr_q, berr_d;
    logic                   oe_q, oe_d;
    logic                   dir_q, dir_d;
    logic                   req_q, req_d;
    logic                   lwr_q, lwr_d;
    logic [WINDOW_BITS-3:0] laddr_q, laddr_d;
    logic [3:0]             be_q, be_d;

    logic am_ok;
    logic in_window;
    logic lword_bad;

    always_comb begin
        case (am_q)
            AM_A24_SUP_DATA, AM_A24_SUP_PROG:   am_ok = 1'b1;
            AM_A24_USER_DATA, AM_A24_USER_PROG: am_ok = !SUPERVISOR_ONLY;
            default:                            am_ok = 1'b0;
        endcase
    end

    // addr_q[k] holds A[k+1]
    assign in_window = (addr_q[22:WINDOW_BITS-1] == BASE_ADDR[23:WINDOW_BITS]);
    assign lword_bad = (lword_q == ACTIVE) && (addr_q[0] || (ds_q != {ACTIVE, ACTIVE}));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        am_d    = am_q;
        write_d = write_q;
        lword_d = lword_q;
        iack_d  = iack_q;
        ds_d    = ds_q;
        timer_d = timer_q;
        dtack_d = dtack_q;
        berr_d  = berr_q;
        oe_d    = oe_q;
        dir_d   = dir_q;
        req_d   = req_q;
        lwr_d   = lwr_q;
        laddr_d = laddr_q;
        be_d    = be_q;

        case (state_q)
            ST_IDLE: begin
                if ((as_s == ACTIVE) && (ds_s != {INACTIVE, INACTIVE})) begin
                    addr_d  = vme_address;
                    am_d    = vme_address_mod;
                    write_d = vme_write;
                    lword_d = vme_lword;
                    iack_d  = vme_iack;
                    ds_d    = ds_s;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if ((iack_q == ACTIVE) || !am_ok || !in_window) begin
                    dtack_d = INACTIVE;
                    berr_d  = INACTIVE;
                    oe_d    = INACTIVE;
                    state_d = ST_IGNORE;
                end else if (lword_bad) begin
                    berr_d  = ACTIVE;
                    oe_d    = INACTIVE;
                    state_d = ST_ERROR;
                end else begin
                    req_d   = 1'b1;
                    lwr_d   = (write_q == ACTIVE);
                    laddr_d = addr_q[WINDOW_BITS-2:1];
                    be_d    = be_from_vme(lword_q, addr_q[0], ds_q);
                    oe_d    = ACTIVE;
                    dir_d   = (write_q == ACTIVE) ? DIR_IN : DIR_OUT;
                    timer_d = TIMEOUT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // err beats ack; ack beats a timeout landing in the same clock
                if (local_err) begin
                    req_d   = 1'b0;
                    berr_d  = ACTIVE;
                    oe_d    = INACTIVE;
                    state_d = ST_ERROR;
                end else if (local_ack) begin
                    req_d   = 1'b0;
                    dtack_d = ACTIVE;
                    state_d = ST_ACK;
                end else if (timer_q == '0) begin
                    req_d   = 1'b0;
                    berr_d  = ACTIVE;
                    oe_d    = INACTIVE;
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_ACK, ST_ERROR, ST_IGNORE: begin
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (ds_s == {INACTIVE, INACTIVE}) begin
                    dtack_d = INACTIVE;
                    berr_d  = INACTIVE;
                    oe_d    = INACTIVE;
                    if (as_s == INACTIVE) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_RELEASE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_WAIT_RELEASE;
            addr_q  <= '0;
            am_q    <= '0;
            write_q <= INACTIVE;
            lword_q <= INACTIVE;
            iack_q  <= INACTIVE;
            ds_q    <= {INACTIVE, INACTIVE};
            timer_q <= '0;
            dtack_q <= INACTIVE;
            berr_q  <= INACTIVE;
            oe_q    <= INACTIVE;
            dir_q   <= DIR_IN;
            req_q   <= 1'b0;
            lwr_q   <= 1'b0;
            laddr_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            am_q    <= am_d;
            write_q <= write_d;
            lword_q <= lword_d;
            iack_q  <= iack_d;
            ds_q    <= ds_d;
            timer_q <= timer_d;
            dtack_q <= dtack_d;
            berr_q  <= berr_d;
            oe_q    <= oe_d;
            dir_q   <= dir_d;
            req_q   <= req_d;
            lwr_q   <= lwr_d;
            laddr_q <= laddr_d;
            be_q    <= be_d;
        end
    end

    assign vme_dtack   = dtack_q;
    assign vme_berr    = berr_q;
    assign data_oe     = oe_q;
    assign data_dir    = dir_q;
    assign local_req   = req_q;
    assign local_write = lwr_q;
    assign local_addr  = laddr_q;
    assign local_be    = be_q;

endmodule

// File: tb/tb_vme_slave_responder.sv
// Scoreboard bench for vme_slave_responder: a bus master and local-memory responder drive the
// DUT while a monitor compares every local request and bus response against a reference model.
module tb_vme_slave_responder;

    localparam logic [23:0] BASE = 24'hE00000;
    localparam int WB = 20;
    localparam int TO = 64;
    localparam int EV_REQ = 0;
    localparam int EV_DTACK = 1;
    localparam int EV_BERR = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vme_as = 1'b1;
    logic [1:0]  vme_ds = 2'b11;
    logic        vme_lword = 1'b1;
    logic        vme_write = 1'b1;
    logic [5:0]  vme_address_mod = 6'h00;
    logic [23:1] vme_address = '0;
    logic        vme_iack = 1'b1;
    logic        vme_dtack, vme_berr, data_oe, data_dir;
    logic        local_req, local_write;
    logic [17:0] local_addr;
    logic [3:0]  local_be;
    logic        local_ack = 1'b0;
    logic        local_err = 1'b0;

    vme_slave_responder dut (
        .clock           (clock),
        .reset           (reset),
        .vme_as          (vme_as),
        .vme_ds          (vme_ds),
        .vme_lword       (vme_lword),
        .vme_write       (vme_write),
        .vme_address_mod (vme_address_mod),
        .vme_address     (vme_address),
        .vme_iack        (vme_iack),
        .vme_dtack       (vme_dtack),
        .vme_berr        (vme_berr),
        .data_oe         (data_oe),
        .data_dir        (data_dir),
        .local_req       (local_req),
        .local_write     (local_write),
        .local_addr      (local_addr),
        .local_be        (local_be),
        .local_ack       (local_ack),
        .local_err       (local_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int addr;
        int be;
        int wr;
        int dir;
        int lat;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  lkind = 0;   // 0 ack, 1 err, 2 ack+err, 3 silent
    int  ldel = 1;

    logic [5:0] am_tab [8] = '{6'h39, 6'h3A, 6'h3D, 6'h3E, 6'h3D, 6'h39, 6'h29, 6'h0D};

    task automatic cmp(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int outvec();
        return int'({vme_dtack, vme_berr, data_oe, data_dir, local_req, local_write, local_be, local_addr});
    endfunction

    // Reference model: classify the cycle from the bus rules and queue the events it must produce.
    function automatic int model(input logic [23:0] a, input logic [5:0] am, input logic lw_n,
                                 input logic [1:0] ds_n, input logic wr_n, input logic iack_n,
                                 input int kind, input int del);
        ev_t e;
        int  off, nb, resp;
        if (!iack_n) return 0;
        if (!(am inside {6'h39, 6'h3A, 6'h3D, 6'h3E})) return 0;
        if ((int'(a) >> WB) != (int'(BASE) >> WB)) return 0;
        if (!lw_n && (a[1] || ds_n != 2'b00)) begin
            e = '{EV_BERR, 0, 0, 0, 0, -1};
            exp_q.push_back(e);
            return 1;
        end
        if (!lw_n) begin
            off = 0; nb = 4;
        end else if (ds_n == 2'b00) begin
            off = int'(a[1]) * 2; nb = 2;
        end else begin
            off = int'(a[1]) * 2 + ((ds_n == 2'b10) ? 1 : 0); nb = 1;
        end
        e.kind = EV_REQ;
        e.addr = (int'(a) % (1 << WB)) / 4;
        e.be   = 0;
        for (int k = off; k < off + nb; k++) e.be += 1 << (3 - k);
        e.wr  = wr_n ? 0 : 1;
        e.dir = wr_n ? 1 : 0;
        e.lat = 0;
        exp_q.push_back(e);
        resp = (kind == 3) ? 1000 : del;
        if (resp > TO)                  e = '{EV_BERR, 0, 0, 0, 0, TO};
        else if (kind == 1 || kind == 2) e = '{EV_BERR, 0, 0, 0, 0, del};
        else                            e = '{EV_DTACK, 0, 0, 0, 0, del};
        exp_q.push_back(e);
        return 1;
    endfunction

    task automatic check_ev(input int kind, input int lat);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d, required no event (t=%0t)", kind, $time);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind) begin
            n_bad++;
            $display("FAIL event_kind: got %0d required %0d (t=%0t)", kind, e.kind, $time);
            return;
        end
        if (kind == EV_REQ) begin
            cmp("local_addr", int'(local_addr), e.addr);
            cmp("local_be", int'(local_be), e.be);
            cmp("local_write", int'(local_write), e.wr);
            cmp("data_dir", int'(data_dir), e.dir);
            cmp("data_oe_access", int'(data_oe), 0);
        end else if (e.lat >= 0) begin
            cmp("response_latency", lat, e.lat);
        end
    endtask

    // Monitor: edge-detect DUT outputs on the falling clock edge.
    logic rq_p = 1'b0, dt_p = 1'b1, be_p = 1'b1;
    int   rise = 0;
    initial begin
        forever begin
            @(negedge clock);
            if (local_req && !rq_p) begin
                rise = cyc;
                check_ev(EV_REQ, 0);
            end
            if (!vme_dtack && dt_p) check_ev(EV_DTACK, cyc - rise);
            if (!vme_berr && be_p) begin
                check_ev(EV_BERR, cyc - rise);
                cmp("req_low_with_berr", int'(local_req), 0);
            end
            rq_p = local_req;
            dt_p = vme_dtack;
            be_p = vme_berr;
        end
    end

    // Local memory side: answer each new request according to lkind/ldel.
    logic req_seen = 1'b0;
    initial begin
        forever begin
            @(negedge clock);
            if (local_req && !req_seen) begin
                req_seen = 1'b1;
                if (lkind != 3) begin
                    repeat (ldel - 1) @(negedge clock);
                    local_ack = (lkind == 0 || lkind == 2);
                    local_err = (lkind == 1 || lkind == 2);
                    @(negedge clock);
                    local_ack = 1'b0;
                    local_err = 1'b0;
                end
            end
            if (!local_req) req_seen = 1'b0;
        end
    end

    // mode: 0 normal, 2 master abort at local_req, 3 pipelined AS while DTACK held
    task automatic vme_cycle(input logic [23:0] a, input logic [5:0] am, input logic lw_n,
                             input logic [1:0] ds_n, input logic wr_n, input logic iack_n,
                             input int kind, input int del, input int mode);
        int resp, w;
        lkind = kind;
        ldel  = del;
        resp  = model(a, am, lw_n, ds_n, wr_n, iack_n, kind, del);
        @(negedge clock);
        vme_address = a[23:1]; vme_address_mod = am; vme_lword = lw_n;
        vme_write = wr_n; vme_iack = iack_n;
        @(negedge clock);
        vme_as = 1'b0;
        @(negedge clock);
        vme_ds = ds_n;
        if (resp == 0) begin
            repeat (40) @(negedge clock);
            cmp("ignored_quiet", int'({vme_dtack, vme_berr, local_req}), 6);
            vme_ds = 2'b11;
        end else if (mode == 2) begin
            w = 0;
            while (!local_req && w < 30) begin @(negedge clock); w++; end
            cmp("abort_req_seen", int'(local_req), 1);
            vme_as = 1'b1;
            vme_ds = 2'b11;
            repeat (80) @(negedge clock);
            cmp("abort_quiet", int'({vme_dtack, vme_berr, local_req}), 6);
        end else begin
            w = 0;
            while (vme_dtack && vme_berr && w < 200) begin @(negedge clock); w++; end
            cmp("response_seen", (vme_dtack && vme_berr) ? 0 : 1, 1);
            repeat (4) @(negedge clock);
            cmp("response_held", (vme_dtack && vme_berr) ? 0 : 1, 1);
            if (mode == 3) begin
                vme_as = 1'b1;
                @(negedge clock);
                vme_as = 1'b0;
                @(negedge clock);
            end
            vme_ds = 2'b11;
            w = 0;
            while (!(vme_dtack && vme_berr) && w < 10) begin @(negedge clock); w++; end
            cmp("release_after_ds", (vme_dtack && vme_berr) ? 1 : 0, 1);
            cmp("data_oe_released", int'(data_oe), 1);
            if (mode == 3) begin
                repeat (3) @(negedge clock);
                vme_ds = ds_n;
                repeat (40) @(negedge clock);
                cmp("pipelined_ignored", int'({vme_dtack, vme_berr, local_req}), 6);
                vme_ds = 2'b11;
            end
        end
        @(negedge clock);
        vme_as = 1'b1;
        repeat (5) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [5:0]  am;
        logic        lw_n, wr_n, iack_n;
        logic [1:0]  ds_n;
        int          sz, r, kind, w;
        ev_t         tmp;

        repeat (3) @(negedge clock);
        cmp("reset_outputs", outvec(), 28'hE000000);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        vme_cycle(24'hE00010, 6'h3D, 1'b0, 2'b00, 1'b1, 1'b1, 0, 3, 0);
        vme_cycle(24'hE00003, 6'h39, 1'b1, 2'b10, 1'b0, 1'b1, 0, 2, 0);
        vme_cycle(24'hD00000, 6'h3D, 1'b0, 2'b00, 1'b1, 1'b1, 0, 2, 0);
        vme_cycle(24'hE00020, 6'h29, 1'b0, 2'b00, 1'b1, 1'b1, 0, 2, 0);
        vme_cycle(24'hE00100, 6'h3E, 1'b0, 2'b00, 1'b1, 1'b1, 3, 1, 0);
        vme_cycle(24'hE00002, 6'h3D, 1'b0, 2'b00, 1'b1, 1'b1, 0, 2, 0);
        vme_cycle(24'hE80006, 6'h3A, 1'b1, 2'b00, 1'b0, 1'b1, 0, 64, 0);
        vme_cycle(24'hE80008, 6'h3A, 1'b1, 2'b00, 1'b1, 1'b1, 0, 65, 0);
        vme_cycle(24'hEFFFFC, 6'h3D, 1'b0, 2'b00, 1'b0, 1'b1, 2, 2, 0);
        vme_cycle(24'hE00044, 6'h3D, 1'b0, 2'b00, 1'b1, 1'b0, 0, 2, 0);
        vme_cycle(24'hE00200, 6'h3D, 1'b1, 2'b01, 1'b1, 1'b1, 0, 6, 2);
        vme_cycle(24'hE00300, 6'h3D, 1'b0, 2'b00, 1'b1, 1'b1, 0, 2, 3);

        // address-only cycle
        vme_address = 23'h700000;
        vme_address_mod = 6'h3D;
        @(negedge clock);
        vme_as = 1'b0;
        repeat (20) @(negedge clock);
        cmp("addr_only_quiet", int'({vme_dtack, vme_berr, local_req}), 6);
        vme_as = 1'b1;
        repeat (5) @(negedge clock);

        // reset during ACCESS with AS/DS held low
        lkind = 3;
        void'(model(24'hE00040, 6'h3D, 1'b0, 2'b00, 1'b1, 1'b1, 3, 1));
        tmp = exp_q.pop_back();
        vme_address = 23'h700020; vme_address_mod = 6'h3D; vme_lword = 1'b0;
        vme_write = 1'b1; vme_iack = 1'b1;
        @(negedge clock);
        vme_as = 1'b0;
        @(negedge clock);
        vme_ds = 2'b00;
        w = 0;
        while (!local_req && w < 30) begin @(negedge clock); w++; end
        cmp("reset_test_req", int'(local_req), 1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        cmp("reset_mid_outputs", outvec(), 28'hE000000);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        cmp("after_reset_quiet", int'({vme_dtack, vme_berr, local_req}), 6);
        vme_ds = 2'b11;
        vme_as = 1'b1;
        repeat (6) @(negedge clock);
        vme_cycle(24'hE00040, 6'h3D, 1'b0, 2'b00, 1'b0, 1'b1, 0, 4, 0);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 24'($urandom) : (BASE | 24'($urandom_range(0, (1 << WB) - 1)));
            am = am_tab[$urandom_range(0, 7)];
            sz = $urandom_range(0, 6);
            if (sz <= 1) begin
                lw_n = 1'b0; ds_n = 2'b00;
                a[1] = ($urandom_range(0, 4) == 0);
            end else if (sz <= 3) begin
                lw_n = 1'b1; ds_n = 2'b00;
            end else if (sz <= 5) begin
                lw_n = 1'b1; ds_n = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            end else begin
                lw_n = 1'b0; ds_n = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            end
            wr_n   = 1'($urandom_range(0, 1));
            iack_n = ($urandom_range(0, 15) != 0);
            r = $urandom_range(0, 19);
            kind = (r < 14) ? 0 : (r < 17) ? 1 : (r < 19) ? 2 : 3;
            vme_cycle(a, am, lw_n, ds_n, wr_n, iack_n, kind, $urandom_range(1, 12), 0);
        end

        repeat (20) @(negedge clock);
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
